// File: rtl/skidbuf.sv
// skidbuf: two-entry elastic pipeline register with valid/ready on both sides.
// Main holds the head entry and drives OutData directly. Skid catches the one
// extra beat that arrives in the cycle the consumer stalls. InReady and
// OutValid are decoded from the state register alone, so neither ready nor
// valid propagates combinationally through this stage.
module skidbuf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [1:0]       Count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, skid_reg;

  logic in_xfer, out_xfer;
  logic main_load_in, main_load_skid, skid_load;

  assign InReady  = (state_reg != FULL);
  assign OutValid = (state_reg != EMPTY);
  assign OutData  = main_reg;
  assign Count    = state_reg;

  assign in_xfer  = InValid & InReady;
  assign out_xfer = OutValid & OutReady;

  // Next state and register load enables; Flush overrides any handshake.
  always_comb begin
    state_next     = state_reg;
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    skid_load      = 1'b0;
    if (Flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (in_xfer) begin
            state_next   = ONE;
            main_load_in = 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_load_in = 1'b1;
          end else if (in_xfer) begin
            state_next = FULL;
            skid_load  = 1'b1;
          end else if (out_xfer) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_next     = ONE;
            main_load_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Main register: loads from the input or is refilled from Skid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_reg <= '0;
    end else if (main_load_skid) begin
      main_reg <= skid_reg;
    end else if (main_load_in) begin
      main_reg <= InData;
    end
  end

  // Skid register: only written when a beat arrives while the head stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_reg <= '0;
    end else if (skid_load) begin
      skid_reg <= InData;
    end
  end

endmodule
